// File: rtl/micro_ucr_pkg.sv
// Shared definitions for the micro-hash nonce sequencer: FSM states,
// datapath widths, the default sample point of the round counter and
// the byte comparison used against the difficulty target.
package micro_ucr_pkg;

  localparam int CNT_W   = 6;
  localparam int H_W     = 24;
  localparam int BLK_W   = 128;
  localparam int NONCE_W = 32;
  localparam int HDR_W   = BLK_W - NONCE_W;
  localparam int TGT_W   = 8;

  // H is folded by the core on counter 33, so it is stable on 34.
  localparam logic [CNT_W-1:0] CNT_LAST_DEF = 6'd34;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    FOUND   = 2'd2,
    DONE_NF = 2'd3
  } state_t;

  // Unsigned "strictly below target" test for one byte of H.
  function automatic logic byte_below(input logic [7:0] b, input logic [TGT_W-1:0] t);
    return (b < t);
  endfunction

endpackage

// File: rtl/micro_ucr_nonce_ctrl_if.sv
// Bundle of the sequencer's control, block and status signals.
// master = the side that issues start/header/target and returns H,
// slave  = the nonce sequencer itself.
interface micro_ucr_nonce_ctrl_if;
  import micro_ucr_pkg::*;

  logic                   start;
  logic [HDR_W-1:0]       header;
  logic [TGT_W-1:0]       target;
  logic [H_W-1:0]         H_in;
  logic [BLK_W-1:0]       bloque_out;
  logic [CNT_W-1:0]       counter_out;
  logic                   fin;
  logic                   busy;
  logic                   found;
  logic                   exhausted;
  logic [NONCE_W-1:0]     nonce_found;

  modport master (
    output start, header, target, H_in,
    input  bloque_out, counter_out, fin, busy, found, exhausted, nonce_found
  );

  modport slave (
    input  start, header, target, H_in,
    output bloque_out, counter_out, fin, busy, found, exhausted, nonce_found
  );

endinterface

// File: rtl/micro_ucr_target_cmp.sv
// Difficulty comparator: a hit needs both upper bytes of H to be strictly
// below the target. The low byte of H never takes part, so only the upper
// 16 bits are brought in.
module micro_ucr_target_cmp
  import micro_ucr_pkg::*;
(
  input  logic [15:0]      i_h_hi,
  input  logic [TGT_W-1:0] i_target,
  output logic             o_hit
);

  assign o_hit = byte_below(i_h_hi[15:8], i_target) && byte_below(i_h_hi[7:0], i_target);

endmodule

// File: rtl/micro_ucr_nonce_ctrl.sv
// Nonce sequencer upstream of the micro-hash core. Presents {header, nonce}
// as the block, drives the round counter, samples H at the end of each
// sweep and either stops on a hit, stops when the nonce range runs out,
// or moves on to the next nonce. fin freezes the core whenever no sweep
// is in progress.
module micro_ucr_nonce_ctrl
  import micro_ucr_pkg::*;
#(
  parameter logic [NONCE_W-1:0] NONCE_START = 32'h0000_0000,
  parameter logic [NONCE_W-1:0] NONCE_LAST  = 32'hFFFF_FFFF,
  parameter logic [CNT_W-1:0]   CNT_LAST    = CNT_LAST_DEF
)
(
  input  logic                    clk,
  input  logic                    reset_L,
  micro_ucr_nonce_ctrl_if.slave   bus
);

  state_t               r_state;
  logic [HDR_W-1:0]     r_header;
  logic [TGT_W-1:0]     r_target;
  logic [NONCE_W-1:0]   r_nonce;
  logic [CNT_W-1:0]     r_counter;
  logic                 r_fin;
  logic                 r_busy;
  logic                 r_found;
  logic                 r_exhausted;
  logic [NONCE_W-1:0]   r_nonce_found;
  logic                 w_hit;

  micro_ucr_target_cmp u_cmp (
    .i_h_hi   (bus.H_in[23:8]),
    .i_target (r_target),
    .o_hit    (w_hit)
  );

  // Sequencer FSM with the header/target latches, nonce and round counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state       <= IDLE;
      r_header      <= '0;
      r_target      <= '0;
      r_nonce       <= NONCE_START;
      r_counter     <= '0;
      r_fin         <= 1'b1;
      r_busy        <= 1'b0;
      r_found       <= 1'b0;
      r_exhausted   <= 1'b0;
      r_nonce_found <= '0;
    end else begin
      case (r_state)
        IDLE, FOUND, DONE_NF: begin
          // Results are held until a new start launches the next search.
          if (bus.start) begin
            r_header      <= bus.header;
            r_target      <= bus.target;
            r_nonce       <= NONCE_START;
            r_counter     <= '0;
            r_fin         <= 1'b0;
            r_busy        <= 1'b1;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_nonce_found <= '0;
            r_state       <= RUN;
          end else begin
            r_state <= r_state;
          end
        end

        RUN: begin
          // start is deliberately not looked at here.
          if (r_counter == CNT_LAST) begin
            r_counter <= '0;
            if (w_hit) begin
              r_nonce_found <= r_nonce;
              r_found       <= 1'b1;
              r_fin         <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= FOUND;
            end else if (r_nonce == NONCE_LAST) begin
              r_exhausted   <= 1'b1;
              r_fin         <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= DONE_NF;
            end else begin
              r_nonce       <= r_nonce + 32'd1;
            end
          end else begin
            r_counter <= r_counter + 6'd1;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_counter <= '0;
          r_fin     <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bloque_out  = {r_header, r_nonce};
  assign bus.counter_out = r_counter;
  assign bus.fin         = r_fin;
  assign bus.busy        = r_busy;
  assign bus.found       = r_found;
  assign bus.exhausted   = r_exhausted;
  assign bus.nonce_found = r_nonce_found;

endmodule

// File: tb/tb_micro_ucr_nonce_ctrl.sv
// Self-checking bench for micro_ucr_nonce_ctrl. A small H table stands in
// for the hash core (indexed by the nonce on bloque_out). Each scenario
// pushes the sweep / found / exhausted events it expects into a queue, and
// the monitor pops and compares them as the DUT produces them.
module tb_micro_ucr_nonce_ctrl;

  localparam logic [31:0] NS = 32'd0;
  localparam logic [31:0] NL = 32'd3;
  localparam int          CL = 34;
  localparam int          EV_SWEEP = 0;
  localparam int          EV_FOUND = 1;
  localparam int          EV_DONE  = 2;

  typedef struct {
    int          kind;
    logic [31:0] nonce;
    int          cyc;
  } ev_t;

  logic clk;
  logic reset_L;
  int   n_tests;
  int   n_fail;
  ev_t  exp_q[$];
  logic [23:0] h_tab [0:3];

  micro_ucr_nonce_ctrl_if bus();

  micro_ucr_nonce_ctrl #(
    .NONCE_START (NS),
    .NONCE_LAST  (NL),
    .CNT_LAST    (6'd34)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input int k, input logic [31:0] n, input int c);
    ev_t e;
    e.kind  = k;
    e.nonce = n;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  // Launch a search, stand in for the core, and score every event produced.
  task automatic run_search(input logic [95:0] hdr, input logic [7:0] tgt,
                            input bit pulses, input int max_cyc, input string tag);
    int  rel;
    bit  done;
    ev_t e;
    int  k;
    logic [31:0] n;
    @(negedge clk);
    bus.header = hdr;
    bus.target = tgt;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    rel  = 0;
    done = 1'b0;
    n_tests++;
    if (bus.found !== 1'b0 || bus.exhausted !== 1'b0 || bus.busy !== 1'b1 ||
        bus.counter_out !== 6'd0 || bus.bloque_out !== {hdr, NS}) begin
      n_fail++;
      $display("FAIL %s_accept: found=%b exh=%b busy=%b cnt=%0d blk=%h, required 0 0 1 0 %h",
               tag, bus.found, bus.exhausted, bus.busy, bus.counter_out, bus.bloque_out, {hdr, NS});
    end
    while (!done && rel <= max_cyc) begin
      bus.H_in = h_tab[bus.bloque_out[1:0]];
      k = -1;
      n = 32'd0;
      if (bus.busy) begin
        n_tests++;
        if (bus.counter_out !== 6'(rel % 35) || bus.fin !== 1'b0 || bus.bloque_out[127:32] !== hdr) begin
          n_fail++;
          $display("FAIL %s_sweep@%0d: cnt=%0d fin=%b hdr=%h, required cnt=%0d fin=0 hdr=%h",
                   tag, rel, bus.counter_out, bus.fin, bus.bloque_out[127:32], rel % 35, hdr);
        end
        if (bus.counter_out == 6'(CL)) begin
          k = EV_SWEEP;
          n = bus.bloque_out[31:0];
        end
      end
      if (bus.found) begin
        k = EV_FOUND;
        n = bus.nonce_found;
        done = 1'b1;
      end else if (bus.exhausted) begin
        k = EV_DONE;
        done = 1'b1;
      end
      if (k >= 0) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_event: got kind=%0d nonce=%0d cyc=%0d, required no event",
                   tag, k, n, (k == EV_SWEEP) ? rel + 1 : rel);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== k || e.nonce !== n || e.cyc !== ((k == EV_SWEEP) ? rel + 1 : rel)) begin
            n_fail++;
            $display("FAIL %s_event: got kind=%0d nonce=%0d cyc=%0d, required kind=%0d nonce=%0d cyc=%0d",
                     tag, k, n, (k == EV_SWEEP) ? rel + 1 : rel, e.kind, e.nonce, e.cyc);
          end
        end
      end
      if (done) begin
        n_tests++;
        if (bus.fin !== 1'b1 || bus.busy !== 1'b0 || bus.counter_out !== 6'd0) begin
          n_fail++;
          $display("FAIL %s_end: fin=%b busy=%b cnt=%0d, required 1 0 0",
                   tag, bus.fin, bus.busy, bus.counter_out);
        end
      end
      bus.start = pulses && bus.busy && (bus.counter_out == 6'd5 || bus.counter_out == 6'd20);
      if (!done) begin
        @(posedge clk);
        @(negedge clk);
        rel++;
      end
    end
    bus.start = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no found/exhausted within %0d cycles", tag, max_cyc);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_leftover: %0d expected events not seen, required 0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (bus.fin !== 1'b1 || bus.busy !== 1'b0 || bus.found !== 1'b0 || bus.exhausted !== 1'b0 ||
        bus.counter_out !== 6'd0 || bus.bloque_out !== 128'd0 || bus.nonce_found !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: fin=%b busy=%b found=%b exh=%b cnt=%0d blk=%h nf=%h, required fin=1 rest 0",
               bus.fin, bus.busy, bus.found, bus.exhausted, bus.counter_out, bus.bloque_out, bus.nonce_found);
    end
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    int wait_cyc;
    @(negedge clk);
    bus.header = {12{8'h3C}};
    bus.target = 8'h10;
    bus.H_in   = 24'hFFFFFF;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc = 0;
    while (bus.counter_out != 6'd17 && wait_cyc < 60) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_tests++;
    if (bus.counter_out !== 6'd17 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reach17: cnt=%0d busy=%b, required 17 1", bus.counter_out, bus.busy);
    end
    #2;
    reset_L = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.fin !== 1'b1 || bus.counter_out !== 6'd0 ||
        bus.bloque_out !== 128'd0 || bus.found !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_async_reset: busy=%b fin=%b cnt=%0d blk=%h found=%b, required 0 1 0 0 0",
               bus.busy, bus.fin, bus.counter_out, bus.bloque_out, bus.found);
    end
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_found_third();
    h_tab[0] = 24'hFFFFFF; h_tab[1] = 24'hFFFFFF; h_tab[2] = 24'h0F0F00; h_tab[3] = 24'hFFFFFF;
    push_exp(EV_SWEEP, 32'd0, 35);
    push_exp(EV_SWEEP, 32'd1, 70);
    push_exp(EV_SWEEP, 32'd2, 105);
    push_exp(EV_FOUND, 32'd2, 105);
    run_search({12{8'hA5}}, 8'h10, 1'b0, 200, "found3");
  endtask

  task automatic test_target_zero();
    h_tab[0] = 24'h000000; h_tab[1] = 24'h000000; h_tab[2] = 24'h000000; h_tab[3] = 24'h000000;
    push_exp(EV_SWEEP, 32'd0, 35);
    push_exp(EV_SWEEP, 32'd1, 70);
    push_exp(EV_SWEEP, 32'd2, 105);
    push_exp(EV_SWEEP, 32'd3, 140);
    push_exp(EV_DONE,  32'd0, 140);
    run_search({12{8'h5A}}, 8'h00, 1'b0, 250, "tgt0");
  endtask

  task automatic test_byte_select();
    h_tab[0] = 24'h0F2000; h_tab[1] = 24'h0F0FFF; h_tab[2] = 24'hFFFFFF; h_tab[3] = 24'hFFFFFF;
    push_exp(EV_SWEEP, 32'd0, 35);
    push_exp(EV_SWEEP, 32'd1, 70);
    push_exp(EV_FOUND, 32'd1, 70);
    run_search(96'h0123_4567_89AB_CDEF_0011_2233, 8'h10, 1'b0, 150, "bytesel");
  endtask

  task automatic test_start_ignored();
    h_tab[0] = 24'h0F2000; h_tab[1] = 24'h0F0FFF; h_tab[2] = 24'hFFFFFF; h_tab[3] = 24'hFFFFFF;
    push_exp(EV_SWEEP, 32'd0, 35);
    push_exp(EV_SWEEP, 32'd1, 70);
    push_exp(EV_FOUND, 32'd1, 70);
    run_search(96'hDEAD_BEEF_CAFE_F00D_1357_9BDF, 8'h10, 1'b1, 150, "startign");
  endtask

  task automatic test_restart_from_found();
    n_tests++;
    if (bus.found !== 1'b1 || bus.nonce_found !== 32'd1) begin
      n_fail++;
      $display("FAIL restart_precond: found=%b nf=%0d, required 1 1", bus.found, bus.nonce_found);
    end
    h_tab[0] = 24'h0F0F00; h_tab[1] = 24'hFFFFFF; h_tab[2] = 24'hFFFFFF; h_tab[3] = 24'hFFFFFF;
    push_exp(EV_SWEEP, 32'd0, 35);
    push_exp(EV_FOUND, 32'd0, 35);
    run_search(96'h1111_2222_3333_4444_5555_6666, 8'h20, 1'b0, 100, "restart");
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset_L     = 1'b0;
    bus.start   = 1'b0;
    bus.header  = '0;
    bus.target  = '0;
    bus.H_in    = '0;
    test_reset();
    test_reset_mid_run();
    test_found_third();
    test_target_zero();
    test_byte_select();
    test_start_ignored();
    test_restart_from_found();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
